txn_finish_tracker: RTL

- Cosim-side tracker that sits directly upstream of the dataflow monitor and generates its `finish` input.
- Watches the top kernel's ap_start/ap_ready/ap_done/ap_continue handshake and counts completed transactions.
- Measures per-transaction start-to-done latency, including overlapping (dataflow) transactions.
- Raises a held `finish` once the expected transaction count completes or a watchdog expires, and reports sticky protocol errors.

---
 rtl/txn_track_pkg.sv | 41 ++++
 rtl/ts_fifo.sv | 61 ++++++
 rtl/txn_finish_tracker.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/txn_track_pkg.sv
// Shared types and helpers for the kernel transaction finish tracker.
// Pure declarations: no state, no latency.
// No flow control; everything here is combinational.
package txn_track_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        FINISHED,
        TIMEOUT
    } state_e;

    localparam int CNT_W_DEF           = 32;
    localparam int MAX_OUTSTANDING_DEF = 4;
    localparam int DRAIN_CYCLES_DEF    = 2;

    // Widest supported counter; callers zero-extend and pass a mask for their width.
    localparam int LAT_W = 64;

    typedef struct packed {
        logic [LAT_W-1:0] lat;
        logic [LAT_W-1:0] mn;
        logic [LAT_W-1:0] mx;
    } lat_upd_t;

    function automatic lat_upd_t lat_update(
        input logic [LAT_W-1:0] now,
        input logic [LAT_W-1:0] start_ts,
        input logic [LAT_W-1:0] cur_min,
        input logic [LAT_W-1:0] cur_max,
        input logic [LAT_W-1:0] mask
    );
        lat_upd_t r;
        r.lat = (now - start_ts) & mask;
        r.mn  = (r.lat < cur_min) ? r.lat : cur_min;
        r.mx  = (r.lat > cur_max) ? r.lat : cur_max;
        return r;
    endfunction

endpackage

// File: rtl/ts_fifo.sv
// Register-based timestamp FIFO with simultaneous push/pop.
// Head is visible combinationally; count/full/empty are registered.
// Push when full is dropped unless a pop happens in the same cycle.
module ts_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [W-1:0]           wr_dat_i,
    input  logic                   pop_i,
    output logic [W-1:0]           rd_dat_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == FULL_CNT);
    assign count_o  = count_q;
    assign rd_dat_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wr_dat_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/txn_finish_tracker.sv
// Tracks kernel ap_* handshakes, measures start-to-done latency and raises finish.
// Statistics update one cycle after the event; finish follows the last done by 1+DRAIN_CYCLES.
// Pure observer: never backpressures; events after finish/timeout are ignored.
module txn_finish_tracker
    import txn_track_pkg::*;
#(
    parameter int CNT_W           = CNT_W_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    parameter int DRAIN_CYCLES    = DRAIN_CYCLES_DEF
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               ap_start,
    input  logic                               ap_ready,
    input  logic                               ap_done,
    input  logic                               ap_continue,
    input  logic [15:0]                        expected_txn,
    input  logic [CNT_W-1:0]                   watchdog_limit,
    output logic                               finish,
    output logic                               timeout_err,
    output logic                               proto_err,
    output logic                               overflow_err,
    output logic [15:0]                        done_count,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic [CNT_W-1:0]                   last_latency,
    output logic [CNT_W-1:0]                   min_latency,
    output logic [CNT_W-1:0]                   max_latency
);

    localparam logic [CNT_W-1:0] CNT_MASK   = '1;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic [CNT_W-1:0] wd_lim_q, wd_lim_d;
    logic [CNT_W-1:0] drain_q, drain_d;
    logic [15:0]      exp_q, exp_d;
    logic [15:0]      done_q, done_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] min_q, min_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic             proto_q, proto_d;
    logic             ovf_q, ovf_d;

    logic             accept, complete, active;
    logic             acc, cmp, bypass, counted;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_head;
    logic [CNT_W-1:0] start_ts;
    logic [15:0]      exp_eff;
    lat_upd_t         upd;

    assign accept   = ap_start & ap_ready;
    assign complete = ap_done & ap_continue;

    // The very first accept is handled in IDLE so a same-cycle done can bypass.
    assign active  = (state_q == RUN) | ((state_q == IDLE) & accept);
    assign acc     = active & accept;
    assign cmp     = active & complete;
    assign bypass  = acc & cmp & fifo_empty;
    assign counted = cmp & (acc | ~fifo_empty);

    assign fifo_pop  = cmp & ~fifo_empty;
    assign fifo_push = acc & ~bypass;
    assign start_ts  = bypass ? cyc_q : fifo_head;
    assign exp_eff   = (state_q == IDLE) ? expected_txn : exp_q;

    assign upd = lat_update(LAT_W'(cyc_q), LAT_W'(start_ts), LAT_W'(min_q),
                            LAT_W'(max_q), LAT_W'(CNT_MASK));

    generate
        if (CNT_W < LAT_W) begin : g_lat_hi
            logic unused_lat_hi;
            assign unused_lat_hi = ^{upd.lat[LAT_W-1:CNT_W], upd.mn[LAT_W-1:CNT_W],
                                     upd.mx[LAT_W-1:CNT_W]};
        end
    endgenerate

    ts_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .W     (CNT_W)
    ) u_ts_fifo (
        .clock    (clock),
        .reset    (reset),
        .push_i   (fifo_push),
        .wr_dat_i (cyc_q),
        .pop_i    (fifo_pop),
        .rd_dat_o (fifo_head),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (outstanding)
    );

    always_comb begin
        state_d  = state_q;
        wd_d     = wd_q;
        wd_lim_d = wd_lim_q;
        drain_d  = drain_q;
        exp_d    = exp_q;
        done_d   = done_q;
        last_d   = last_q;
        min_d    = min_q;
        max_d    = max_q;
        proto_d  = proto_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = RUN;
                    exp_d    = expected_txn;
                    wd_lim_d = watchdog_limit;
                    wd_d     = '0;
                end
            end
            RUN: begin
                if (accept | complete) begin
                    wd_d = '0;
                end else begin
                    wd_d = wd_q + 1'b1;
                    if ((wd_lim_q != '0) && (wd_d == wd_lim_q)) begin
                        state_d = TIMEOUT;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = FINISHED;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: ;
        endcase

        if (counted) begin
            done_d = done_q + 16'd1;
            last_d = upd.lat[CNT_W-1:0];
            min_d  = upd.mn[CNT_W-1:0];
            max_d  = upd.mx[CNT_W-1:0];
            if ((exp_eff != 16'd0) && (done_d == exp_eff)) begin
                state_d = (DRAIN_CYCLES == 0) ? FINISHED : DRAIN;
                drain_d = '0;
            end
        end
        if (cmp & ~acc & fifo_empty) begin
            proto_d = 1'b1;
        end
        if (acc & ~cmp & fifo_full) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cyc_q    <= '0;
            wd_q     <= '0;
            wd_lim_q <= '0;
            drain_q  <= '0;
            exp_q    <= '0;
            done_q   <= '0;
            last_q   <= '0;
            min_q    <= '1;
            max_q    <= '0;
            proto_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_q + 1'b1;
            wd_q     <= wd_d;
            wd_lim_q <= wd_lim_d;
            drain_q  <= drain_d;
            exp_q    <= exp_d;
            done_q   <= done_d;
            last_q   <= last_d;
            min_q    <= min_d;
            max_q    <= max_d;
            proto_q  <= proto_d;
            ovf_q    <= ovf_d;
        end
    end

    assign finish       = (state_q == FINISHED) | (state_q == TIMEOUT);
    assign timeout_err  = (state_q == TIMEOUT);
    assign proto_err    = proto_q;
    assign overflow_err = ovf_q;
    assign done_count   = done_q;
    assign last_latency = last_q;
    assign min_latency  = min_q;
    assign max_latency  = max_q;

endmodule
